// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM encoding and the
// registered control-output bundle that each state drives.
package imem_loader_pkg;

   localparam int DEFAULT_DEPTH = 64;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN0 = 3'd1,
      S_LEN1 = 3'd2,
      S_DATA = 3'd3,
      S_CSUM = 3'd4,
      S_DONE = 3'd5,
      S_ERR  = 3'd6
   } state_t;

   typedef struct packed {
      logic in_ready;
      logic busy;
      logic done;
      logic err;
      logic cpu_reset;
   } ctl_t;

   // Control outputs are loaded together with the state they belong to,
   // so every output is a flop that matches the state it sits beside.
   function automatic ctl_t ctl_for(state_t s);
      ctl_t c;
      c = '{in_ready: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0, cpu_reset: 1'b1};
      case (s)
         S_LEN0, S_LEN1, S_DATA, S_CSUM: begin
            c.in_ready = 1'b1;
            c.busy     = 1'b1;
         end
         S_DONE: begin
            c.done      = 1'b1;
            c.cpu_reset = 1'b0;
         end
         S_ERR:   c.err = 1'b1;
         default: c = c;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Packs bytes LSB-first into a 32-bit word; word_valid pulses the cycle
// after the fourth byte is shifted in.
module byte_word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        shift,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_valid,
   output logic [1:0]  byte_cnt
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         word       <= '0;
         word_valid <= 1'b0;
         byte_cnt   <= '0;
      end else begin
         word_valid <= shift && (byte_cnt == 2'd3);
         if (shift) begin
            // First byte ends up in [7:0] after four shifts.
            word     <= {byte_in, word[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: header, payload words,
// XOR checksum. Keeps the core in reset until a load verifies.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        we,
   output logic [31:0] wa,
   output logic [31:0] wd,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic        err
);

   // state  | meaning
   // IDLE   | post-reset, waiting for start, core held in reset
   // LEN0   | expecting length low byte
   // LEN1   | expecting length high byte, length validated here
   // DATA   | payload bytes, one memory write per four bytes
   // CSUM   | expecting checksum byte
   // DONE   | load verified, core released
   // ERR    | bad length or checksum, core held in reset

   state_t        state;
   ctl_t          ctl;
   logic [7:0]    len_lo;
   logic [7:0]    xor_acc;
   logic [AW:0]   words_left;
   logic [AW-1:0] word_idx;
   logic [1:0]    byte_cnt;
   logic [15:0]   len_full;
   logic          len_bad;
   logic          hs;
   logic          pk_shift;
   logic          pk_clr;

   assign hs       = in_valid & ctl.in_ready;
   assign pk_shift = hs && (state == S_DATA);
   assign pk_clr   = hs && (state == S_LEN1);
   assign len_full = {in_data, len_lo};
   assign len_bad  = (len_full == 16'd0) || (len_full > 16'(DEPTH));

   assign in_ready  = ctl.in_ready;
   assign busy      = ctl.busy;
   assign done      = ctl.done;
   assign err       = ctl.err;
   assign cpu_reset = ctl.cpu_reset;

   byte_word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clr        (pk_clr),
      .shift      (pk_shift),
      .byte_in    (in_data),
      .word       (wd),
      .word_valid (we),
      .byte_cnt   (byte_cnt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         ctl        <= ctl_for(S_IDLE);
         wa         <= '0;
         len_lo     <= '0;
         xor_acc    <= '0;
         words_left <= '0;
         word_idx   <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state <= S_LEN0;
                  ctl   <= ctl_for(S_LEN0);
               end
            end
            S_LEN0: begin
               if (hs) begin
                  len_lo <= in_data;
                  state  <= S_LEN1;
                  ctl    <= ctl_for(S_LEN1);
               end
            end
            S_LEN1: begin
               if (hs) begin
                  if (len_bad) begin
                     state <= S_ERR;
                     ctl   <= ctl_for(S_ERR);
                  end else begin
                     words_left <= len_full[AW:0];
                     word_idx   <= '0;
                     xor_acc    <= '0;
                     state      <= S_DATA;
                     ctl        <= ctl_for(S_DATA);
                  end
               end
            end
            S_DATA: begin
               if (hs) begin
                  xor_acc <= xor_acc ^ in_data;
                  // wa is registered alongside the packer's word_valid flop.
                  if (byte_cnt == 2'd3) begin
                     wa         <= {{(30-AW){1'b0}}, word_idx, 2'b00};
                     word_idx   <= word_idx + AW'(1);
                     words_left <= words_left - (AW+1)'(1);
                     if (words_left == (AW+1)'(1)) begin
                        state <= S_CSUM;
                        ctl   <= ctl_for(S_CSUM);
                     end
                  end
               end
            end
            S_CSUM: begin
               if (hs) begin
                  if (in_data == xor_acc) begin
                     state <= S_DONE;
                     ctl   <= ctl_for(S_DONE);
                  end else begin
                     state <= S_ERR;
                     ctl   <= ctl_for(S_ERR);
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               ctl   <= ctl_for(S_IDLE);
            end
         endcase
      end
   end

endmodule
